axi_rd_burst_arbiter: RTL and testbench
=======================================

Name: axi_rd_burst_arbiter

Overview:
- Shares one AXI4 read master port (AR + R channels) between C_NUM_REQ independent read masters, e.g. the NFA and query readers feeding the kernel input channel.
- Arbitrates round-robin at burst (AR) granularity.
- Records the grant order in a route FIFO and steers R beats back to the owning requester, relying on AXI in-order return for a single ID.
- Sits between the per-stream AXI read masters and the kernel m_axi port.

Parameters:
- C_NUM_REQ, 2, number of requesters (range 2..4).
- C_M_AXI_ADDR_WIDTH, 64, address width.
- C_M_AXI_DATA_WIDTH, 512, data width.
- C_MAX_OUTSTANDING, 16, maximum bursts in flight and route FIFO depth (power of 2, ≥2).

Ports:
- aclk  in  1  clock
- areset  in  1  reset
- s_axi_arvalid  in  C_NUM_REQ  per-requester AR valid
- s_axi_arready  out  C_NUM_REQ  per-requester AR ready
- s_axi_araddr  in  C_NUM_REQ*C_M_AXI_ADDR_WIDTH  packed; requester i at slice i
- s_axi_arlen  in  C_NUM_REQ*8  packed burst lengths
- s_axi_rvalid  out  C_NUM_REQ  per-requester R valid
- s_axi_rready  in  C_NUM_REQ  per-requester R ready
- s_axi_rdata  out  C_M_AXI_DATA_WIDTH  broadcast R data
- s_axi_rlast  out  1  broadcast R last
- m_axi_arvalid / m_axi_arready / m_axi_araddr / m_axi_arlen  out/in/out/out  1/1/ADDR/8  shared AR
- m_axi_rvalid / m_axi_rready / m_axi_rdata / m_axi_rlast  in/out/in/in  1/1/DATA/1  shared R
- busy  out  1  high while any burst is outstanding or m_axi_arvalid is high

Behaviour:
- Clock and reset:
  - Single clock aclk.
  - areset is synchronous, active-high.
  - Reset values: m_axi_arvalid=0, araddr=0, arlen=0, all s_axi_arready=0, route FIFO empty, RR pointer=0, busy=0.
- AR output register:
  - Registered slice; loads when slot_free = !m_axi_arvalid || m_axi_arready.
  - Grant enable gnt_en = slot_free && !fifo_full.
- Arbitration:
  - Combinational round-robin over s_axi_arvalid, starting at rr_ptr.
  - The winner w gets s_axi_arready[w]=gnt_en; all other readies are 0.
  - No requester's arready is asserted without its arvalid.
- On the grant handshake:
  - Load addr and len of w into the output register; m_axi_arvalid=1 on the next cycle (1-cycle latency).
  - Push w into the route FIFO.
  - rr_ptr <= (w+1) mod C_NUM_REQ.
- Without a handshake, m_axi_arvalid clears after m_axi_arready. Back-to-back grants every cycle are allowed while m_axi_arready=1 and the FIFO is not full.
- Route FIFO:
  - Depth C_MAX_OUTSTANDING; pointers are log2(depth)+1 bits and wrap naturally.
  - full = MSBs differ and LSBs equal.
  - Push on an AR grant; pop on m_axi_rvalid && m_axi_rready && m_axi_rlast.
  - full is evaluated before the same-cycle pop: at full, the push is blocked even if a pop occurs that cycle (conservative, 1 bubble).
  - Push and pop in the same cycle when not full: occupancy unchanged.
- R steering (combinational, zero latency), with h = FIFO head:
  - s_axi_rvalid[i] = m_axi_rvalid && !fifo_empty && (h==i).
  - m_axi_rready = !fifo_empty && s_axi_rready[h].
  - rdata and rlast are broadcast unchanged.
- R beat with FIFO empty: m_axi_rready stays 0 (beat not consumed; upstream protocol error, no recovery).
- Reset mid-operation: all in-flight bookkeeping is discarded. The system must also reset the downstream memory interface; stale R beats are not filtered.
- busy = !fifo_empty || m_axi_arvalid.

Optional Feature:
- Macro RDARB_PERF_CNT_EN.
- When defined:
  - Adds output perf_burst_cnt (C_NUM_REQ*32): per-requester count of granted bursts.
  - Adds output perf_full_stall_cnt (32): cycles where any s_axi_arvalid=1 && fifo_full.
  - Counters saturate at 2^32-1 and are cleared by areset.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package rdarb_pkg:
  - LP_ROUTE_W = $clog2(C_NUM_REQ)
  - LP_PTR_W = $clog2(C_MAX_OUTSTANDING)+1
  - typedef route_id_t (logic [LP_ROUTE_W-1:0])
  - perf counter width constant 32
- Sub-module rdarb_route_fifo:
  - Synchronous FIFO of route_id_t.
  - push/pop/head/empty/full, same reset.

Test Plan:
- Single requester 0, addr 0x1000, arlen 3: m_axi_arvalid high 1 cycle after the grant with the same addr/len. 4 R beats reach s_axi_rvalid[0] only; FIFO empty after rlast; busy drops the next cycle.
- Both requesters valid continuously, arready=1: grants alternate 0,1,0,1. m_axi_araddr sequence matches. The R stream is routed in the same order, 4 bursts of arlen 0.
- C_MAX_OUTSTANDING=4, no R returned: exactly 4 grants, then s_axi_arready stays 0. perf_full_stall_cnt increments each stalled cycle (macro on). After one rlast, the next grant occurs 1 cycle later.
- Requester 1 holds s_axi_rready=0 mid-burst: m_axi_rready=0 and data is held. Requester 0's burst queued behind it receives nothing until requester 1 completes.
- m_axi_arready held low 5 cycles with arvalid high: araddr/arlen stable, no further grants. Release, then the next grant proceeds.
- Assert areset with 3 bursts outstanding: next cycle m_axi_arvalid=0, busy=0, FIFO empty, rr_ptr=0 (first grant goes to requester 0 when both request).

Source files
------------

// File: rtl/rdarb_pkg.sv
// Shared types and constants for the AXI read burst arbiter.
// Route IDs are sized for the largest supported requester count (4), so one
// type serves every legal C_NUM_REQ setting.
package rdarb_pkg;

  localparam int LP_MAX_REQ         = 4;
  localparam int LP_ROUTE_W         = $clog2(LP_MAX_REQ);
  localparam int LP_DEF_OUTSTANDING = 16;
  localparam int LP_PTR_W           = $clog2(LP_DEF_OUTSTANDING) + 1;
  localparam int LP_PERF_W          = 32;

  typedef logic [LP_ROUTE_W-1:0] route_id_t;

  // Saturating increment for the performance counters.
  function automatic logic [LP_PERF_W-1:0] sat_inc(input logic [LP_PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rdarb_route_fifo.sv
// Route FIFO: remembers which requester owns each outstanding burst, in grant
// order. Pointers carry one extra wrap bit so full/empty need no counter.
module rdarb_route_fifo
  import rdarb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  route_id_t din_i,
  output route_id_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  route_id_t     mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer values; full/empty come from the registered pointers only.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless while empty so it is not reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/axi_rd_burst_arbiter.sv
// AXI4 read arbiter: round-robin AR grants per burst onto one master port,
// R beats steered back to the owner via an in-order route FIFO.
// Optional per-requester/full-stall counters: define RDARB_PERF_CNT_EN.
module axi_rd_burst_arbiter
  import rdarb_pkg::*;
#(
  parameter int C_NUM_REQ          = 2,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MAX_OUTSTANDING  = 16
) (
  input  logic                                    aclk,
  input  logic                                    areset,
  input  logic [C_NUM_REQ-1:0]                    s_axi_arvalid,
  output logic [C_NUM_REQ-1:0]                    s_axi_arready,
  input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [C_NUM_REQ*8-1:0]                  s_axi_arlen,
  output logic [C_NUM_REQ-1:0]                    s_axi_rvalid,
  input  logic [C_NUM_REQ-1:0]                    s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]           s_axi_rdata,
  output logic                                    s_axi_rlast,
  output logic                                    m_axi_arvalid,
  input  logic                                    m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic [7:0]                              m_axi_arlen,
  input  logic                                    m_axi_rvalid,
  output logic                                    m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic                                    m_axi_rlast,
  output logic                                    busy
`ifdef RDARB_PERF_CNT_EN
  ,
  output logic [C_NUM_REQ*LP_PERF_W-1:0]          perf_burst_cnt,
  output logic [LP_PERF_W-1:0]                    perf_full_stall_cnt
`endif
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;

  logic          arvalid_q, arvalid_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [7:0]    arlen_q, arlen_d;
  route_id_t     rr_ptr_q, rr_ptr_d;

  route_id_t     win;
  logic          any_req;
  logic [AW-1:0] sel_addr;
  logic [7:0]    sel_len;
  logic          slot_free, gnt_en, gnt;

  route_id_t     head;
  logic          fifo_empty, fifo_full, fifo_pop;

  assign slot_free = !arvalid_q || m_axi_arready;
  assign gnt_en    = slot_free && !fifo_full;
  assign gnt       = any_req && gnt_en;

  // Round-robin pick: first requester at or above rr_ptr, else wrap to the lowest.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (!any_req && s_axi_arvalid[i] && (route_id_t'(i) >= rr_ptr_q)) begin
        any_req = 1'b1;
        win     = route_id_t'(i);
      end
    end
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (!any_req && s_axi_arvalid[i]) begin
        any_req = 1'b1;
        win     = route_id_t'(i);
      end
    end
  end

  // Winner's request fields and per-requester ready (only the winner, only when a slot is open).
  always_comb begin
    sel_addr      = '0;
    sel_len       = '0;
    s_axi_arready = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (win == route_id_t'(i)) begin
        sel_addr         = s_axi_araddr[i*AW +: AW];
        sel_len          = s_axi_arlen[i*8 +: 8];
        s_axi_arready[i] = gnt;
      end
    end
  end

  // AR slice next state: load on grant, otherwise drain on downstream accept.
  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    rr_ptr_d  = rr_ptr_q;
    if (gnt) begin
      arvalid_d = 1'b1;
      araddr_d  = sel_addr;
      arlen_d   = sel_len;
      rr_ptr_d  = (win == route_id_t'(C_NUM_REQ-1)) ? '0 : win + 1'b1;
    end else if (m_axi_arready) begin
      arvalid_d = 1'b0;
    end
  end

  // AR slice and round-robin pointer registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      rr_ptr_q  <= '0;
    end else begin
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign fifo_pop      = m_axi_rvalid && m_axi_rready && m_axi_rlast;
  assign busy          = !fifo_empty || arvalid_q;

  rdarb_route_fifo #(
    .DEPTH (C_MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (gnt),
    .pop_i   (fifo_pop),
    .din_i   (win),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // R steering: the FIFO head owns the current beat; nothing is accepted with no owner.
  always_comb begin
    s_axi_rvalid = '0;
    m_axi_rready = 1'b0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (!fifo_empty && (head == route_id_t'(i))) begin
        s_axi_rvalid[i] = m_axi_rvalid;
        m_axi_rready    = s_axi_rready[i];
      end
    end
  end

  assign s_axi_rdata = m_axi_rdata;
  assign s_axi_rlast = m_axi_rlast;

`ifdef RDARB_PERF_CNT_EN
  logic [C_NUM_REQ*LP_PERF_W-1:0] burst_cnt_q;
  logic [LP_PERF_W-1:0]           stall_cnt_q;

  // Saturating grant and full-stall counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      burst_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < C_NUM_REQ; i++) begin
        if (gnt && (win == route_id_t'(i)))
          burst_cnt_q[i*LP_PERF_W +: LP_PERF_W] <= sat_inc(burst_cnt_q[i*LP_PERF_W +: LP_PERF_W]);
      end
      if ((|s_axi_arvalid) && fifo_full) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign perf_burst_cnt      = burst_cnt_q;
  assign perf_full_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axi_rd_burst_arbiter.sv
// Directed bench for axi_rd_burst_arbiter (2 requesters, 4 outstanding bursts).
module tb_axi_rd_burst_arbiter;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int MO = 4;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    s_axi_arvalid;
  logic [N-1:0]    s_axi_arready;
  logic [N*AW-1:0] s_axi_araddr;
  logic [N*8-1:0]  s_axi_arlen;
  logic [N-1:0]    s_axi_rvalid;
  logic [N-1:0]    s_axi_rready;
  logic [DW-1:0]   s_axi_rdata;
  logic            s_axi_rlast;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic            m_axi_rvalid;
  logic            m_axi_rready;
  logic [DW-1:0]   m_axi_rdata;
  logic            m_axi_rlast;
  logic            busy;
`ifdef RDARB_PERF_CNT_EN
  logic [N*32-1:0] perf_burst_cnt;
  logic [31:0]     perf_full_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axi_rd_burst_arbiter #(
    .C_NUM_REQ          (N),
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .C_MAX_OUTSTANDING  (MO)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rlast   (s_axi_rlast),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rlast   (m_axi_rlast),
    .busy          (busy)
`ifdef RDARB_PERF_CNT_EN
    ,
    .perf_burst_cnt      (perf_burst_cnt),
    .perf_full_stall_cnt (perf_full_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ar(input int r, input logic [AW-1:0] a, input logic [7:0] l);
    s_axi_araddr[r*AW +: AW] = a;
    s_axi_arlen[r*8 +: 8]    = l;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  initial begin
    s_axi_arvalid = '0;
    s_axi_araddr  = '0;
    s_axi_arlen   = '0;
    s_axi_rready  = '0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rlast   = 1'b0;
    do_reset();
    settle();
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_araddr", m_axi_araddr, 64'd0);
    chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
    chk("rst_s_arready", 64'(s_axi_arready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Single requester 0, one burst of 4 beats.
    set_ar(0, 64'h1000, 8'd3);
    s_axi_arvalid = 2'b01;
    settle();
    chk("t1_arready", 64'(s_axi_arready), 64'd1);
    tick();
    s_axi_arvalid = 2'b00;
    settle();
    chk("t1_m_arvalid", 64'(m_axi_arvalid), 64'd1);
    chk("t1_m_araddr", m_axi_araddr, 64'h1000);
    chk("t1_m_arlen", 64'(m_axi_arlen), 64'd3);
    chk("t1_busy_ar", 64'(busy), 64'd1);
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    settle();
    chk("t1_arvalid_clr", 64'(m_axi_arvalid), 64'd0);
    chk("t1_busy_out", 64'(busy), 64'd1);
    s_axi_rready = 2'b11;
    for (int b = 0; b < 4; b++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 32'hD0 + 32'(b);
      m_axi_rlast  = (b == 3);
      settle();
      chk("t1_rvalid", 64'(s_axi_rvalid), 64'd1);
      chk("t1_m_rready", 64'(m_axi_rready), 64'd1);
      chk("t1_rdata", 64'(s_axi_rdata), 64'hD0 + 64'(b));
      tick();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    settle();
    chk("t1_busy_done", 64'(busy), 64'd0);
    chk("t1_rvalid_done", 64'(s_axi_rvalid), 64'd0);

    // Both requesting continuously: grants alternate 0,1,0,1.
    do_reset();
    set_ar(0, 64'hA000, 8'd0);
    set_ar(1, 64'hB000, 8'd0);
    s_axi_arvalid = 2'b11;
    m_axi_arready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      settle();
      chk("t2_arready", 64'(s_axi_arready), (g % 2 == 0) ? 64'd1 : 64'd2);
      tick();
      settle();
      chk("t2_araddr", m_axi_araddr, (g % 2 == 0) ? 64'hA000 : 64'hB000);
    end
    s_axi_arvalid = 2'b00;
    tick();
    settle();
    chk("t2_arvalid_clr", 64'(m_axi_arvalid), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    s_axi_rready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = 1'b1;
      m_axi_rdata  = 32'(k);
      settle();
      chk("t2_route", 64'(s_axi_rvalid), (k % 2 == 0) ? 64'd1 : 64'd2);
      tick();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    settle();
    chk("t2_busy_done", 64'(busy), 64'd0);

    // Fill the route FIFO with no R returned, then free one entry.
    set_ar(0, 64'h2000, 8'd1);
    s_axi_arvalid = 2'b01;
    for (int g = 0; g < 4; g++) begin
      settle();
      chk("t3_grant", 64'(s_axi_arready), 64'd1);
      tick();
    end
    for (int s = 0; s < 3; s++) begin
      settle();
      chk("t3_full_block", 64'(s_axi_arready), 64'd0);
      tick();
    end
`ifdef RDARB_PERF_CNT_EN
    settle();
    chk("t3_stall_cnt3", 64'(perf_full_stall_cnt), 64'd3);
`endif
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    settle();
    chk("t3_pop_block", 64'(s_axi_arready), 64'd0);
    chk("t3_pop_route", 64'(s_axi_rvalid), 64'd1);
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    settle();
    chk("t3_regrant", 64'(s_axi_arready), 64'd1);
    tick();
    s_axi_arvalid = 2'b00;
    settle();
    chk("t3_regrant_ar", 64'(m_axi_arvalid), 64'd1);
`ifdef RDARB_PERF_CNT_EN
    chk("t3_stall_cnt4", 64'(perf_full_stall_cnt), 64'd4);
    chk("t3_burst0", 64'(perf_burst_cnt[31:0]), 64'd7);
    chk("t3_burst1", 64'(perf_burst_cnt[63:32]), 64'd2);
`endif
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t3_drain", 64'(s_axi_rvalid), 64'd1);
      tick();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    settle();
    chk("t3_busy_done", 64'(busy), 64'd0);

    // Requester 1 stalls its R mid-burst; requester 0 queued behind it.
    set_ar(0, 64'h4000, 8'd0);
    set_ar(1, 64'h3000, 8'd1);
    s_axi_arvalid = 2'b11;
    settle();
    chk("t4_first", 64'(s_axi_arready), 64'd2);
    tick();
    settle();
    chk("t4_addr1", m_axi_araddr, 64'h3000);
    chk("t4_second", 64'(s_axi_arready), 64'd1);
    tick();
    s_axi_arvalid = 2'b00;
    settle();
    chk("t4_addr0", m_axi_araddr, 64'h4000);
    tick();
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b0;
    m_axi_rdata  = 32'hE0;
    s_axi_rready = 2'b10;
    settle();
    chk("t4_b0_route", 64'(s_axi_rvalid), 64'd2);
    chk("t4_b0_rready", 64'(m_axi_rready), 64'd1);
    tick();
    m_axi_rlast  = 1'b1;
    m_axi_rdata  = 32'hE1;
    s_axi_rready = 2'b00;
    settle();
    chk("t4_hold_rready", 64'(m_axi_rready), 64'd0);
    chk("t4_hold_route", 64'(s_axi_rvalid), 64'd2);
    tick();
    s_axi_rready = 2'b01;
    settle();
    chk("t4_other_rready", 64'(m_axi_rready), 64'd0);
    chk("t4_other_route", 64'(s_axi_rvalid), 64'd2);
    chk("t4_rdata_held", 64'(s_axi_rdata), 64'hE1);
    tick();
    s_axi_rready = 2'b10;
    settle();
    chk("t4_release", 64'(m_axi_rready), 64'd1);
    tick();
    m_axi_rdata  = 32'hE2;
    s_axi_rready = 2'b01;
    settle();
    chk("t4_req0_route", 64'(s_axi_rvalid), 64'd1);
    chk("t4_req0_rready", 64'(m_axi_rready), 64'd1);
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    settle();
    chk("t4_busy_done", 64'(busy), 64'd0);

    // Downstream AR backpressure for 5 cycles.
    m_axi_arready = 1'b0;
    set_ar(0, 64'h5000, 8'd7);
    set_ar(1, 64'h6000, 8'd2);
    s_axi_arvalid = 2'b11;
    settle();
    chk("t5_first", 64'(s_axi_arready), 64'd2);
    tick();
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t5_no_grant", 64'(s_axi_arready), 64'd0);
      chk("t5_addr_stable", m_axi_araddr, 64'h6000);
      chk("t5_len_stable", 64'(m_axi_arlen), 64'd2);
      tick();
    end
    m_axi_arready = 1'b1;
    settle();
    chk("t5_next_grant", 64'(s_axi_arready), 64'd1);
    tick();
    s_axi_arvalid = 2'b00;
    settle();
    chk("t5_addr_next", m_axi_araddr, 64'h5000);
    chk("t5_len_next", 64'(m_axi_arlen), 64'd7);
    chk("t5_arvalid", 64'(m_axi_arvalid), 64'd1);
    tick();
    settle();
    chk("t5_arvalid_clr", 64'(m_axi_arvalid), 64'd0);

    // Reset with 3 bursts outstanding.
    set_ar(1, 64'h7000, 8'd0);
    s_axi_arvalid = 2'b10;
    settle();
    chk("t6_third", 64'(s_axi_arready), 64'd2);
    tick();
    s_axi_arvalid = 2'b00;
    areset        = 1'b1;
    m_axi_rvalid  = 1'b1;
    tick();
    settle();
    chk("t6_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_araddr", m_axi_araddr, 64'd0);
    chk("t6_rvalid", 64'(s_axi_rvalid), 64'd0);
    chk("t6_m_rready", 64'(m_axi_rready), 64'd0);
`ifdef RDARB_PERF_CNT_EN
    chk("t6_stall_clr", 64'(perf_full_stall_cnt), 64'd0);
`endif
    areset       = 1'b0;
    m_axi_rvalid = 1'b0;
    set_ar(0, 64'h8000, 8'd0);
    s_axi_arvalid = 2'b11;
    settle();
    chk("t6_rr_zero", 64'(s_axi_arready), 64'd1);
    tick();
    s_axi_arvalid = 2'b00;
    settle();
    chk("t6_addr", m_axi_araddr, 64'h8000);
    chk("t6_arvalid_set", 64'(m_axi_arvalid), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
